spi_motor_master: RTL and testbench

FPGA-side SPI master that serialises one 16-bit motor command frame, {motor1, motor2}, MSB first, onto sck/sdo. It drives the same pins and bit order that the `spi` slave block consumes, so it serves as the transmit end of the motor-command link. It is used for board-to-board forwarding and as a synthesizable stimulus source in place of hand-timed bench pulses. Bits returned on sdi are captured into rx_data for loopback and echo checks.

---
 rtl/spi_motor_master.sv | 116 +++++++++++
 tb/tb_spi_motor_master.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_motor_master.sv
// SPI master that sends one 16-bit motor command {motor1, motor2} MSB first on sck/sdo.
// Bits returned on sdi are shifted in on each sck rise and published on rx_data at frame end.
module spi_motor_master #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  motor1,
  input  logic [7:0]  motor2,
  output logic        busy,
  output logic        done,
  output logic [15:0] rx_data,
  output logic        sck,
  output logic        sdo,
  input  logic        sdi,
  output logic        load
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, TAIL} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] div_cnt;
  logic [3:0]    bit_cnt;
  logic [15:0]   tx_sh;
  logic [15:0]   rx_sh;
  logic          phase_end;

  assign phase_end = (div_cnt == DIV_LAST);
  assign sdo       = tx_sh[15];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    sck       = 1'b0;
    load      = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: if (start) state_nxt = LEAD;
      LEAD: begin
        load = 1'b1;
        busy = 1'b1;
        if (phase_end) state_nxt = HIGH;
      end
      HIGH: begin
        load = 1'b1;
        busy = 1'b1;
        sck  = 1'b1;
        if (phase_end) state_nxt = (bit_cnt == 4'd15) ? TAIL : LOW;
      end
      LOW: begin
        load = 1'b1;
        busy = 1'b1;
        if (phase_end) state_nxt = HIGH;
      end
      TAIL: begin
        load = 1'b1;
        busy = 1'b1;
        if (phase_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift registers move only on phase entries: capture on the way into HIGH
  // (the sck rise), advance sdo on the way into LOW so it changes while sck is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      rx_data <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;

      if (state == IDLE) begin
        if (start) begin
          tx_sh   <= {motor1, motor2};
          bit_cnt <= '0;
          div_cnt <= '0;
        end
      end else if (phase_end) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (state != HIGH && state_nxt == HIGH)
        rx_sh <= {rx_sh[14:0], sdi};

      if (state != LOW && state_nxt == LOW) begin
        tx_sh   <= {tx_sh[14:0], 1'b0};
        bit_cnt <= bit_cnt + 4'd1;
      end

      if (state == TAIL && phase_end) begin
        rx_data <= rx_sh;
        done    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_motor_master.sv
// Self-checking bench for spi_motor_master: a cycle-indexed frame model checks every
// cycle, and directed scenarios pin frame contents, timing, back-to-back and abort.
module tb_spi_motor_master;

  localparam int D     = 4;
  localparam int FRAME = 33 * D;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  motor1 = 8'h00;
  logic [7:0]  motor2 = 8'h00;
  logic        busy, done, sck, sdo, load, sdi;
  logic [15:0] rx_data;
  logic        loopback = 1'b1;
  logic        rnd_sdi = 1'b0;

  assign sdi = loopback ? sdo : rnd_sdi;

  spi_motor_master #(.CLK_DIV(D)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .motor1  (motor1),
    .motor2  (motor2),
    .busy    (busy),
    .done    (done),
    .rx_data (rx_data),
    .sck     (sck),
    .sdo     (sdo),
    .sdi     (sdi),
    .load    (load)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: a frame is a cycle index k = 0 .. 33*D-1 after acceptance.
  // sck is high in the 16 windows [D + 2*D*i, 2*D + 2*D*i); bit j = k / (2*D) is on sdo.
  int          k = -1;
  logic        m_done = 1'b0;
  logic        m_idle_sdo = 1'b0;
  logic [15:0] m_frame = '0;
  logic [15:0] m_cap = '0;
  logic [15:0] m_rx = '0;

  function automatic logic exp_sck(input int kk);
    return (kk >= D) && (kk < 32 * D) && (((kk - D) / D) % 2 == 0);
  endfunction

  always @(negedge clk) begin
    logic [20:0] exp_v;
    logic [20:0] act_v;
    int          j;
    if (reset) begin
      k          = -1;
      m_done     = 1'b0;
      m_rx       = '0;
      m_idle_sdo = 1'b0;
    end else begin
      if (k < 0) begin
        exp_v = {3'b000, m_idle_sdo, m_done, m_rx};
      end else begin
        j = k / (2 * D);
        if (j > 15) j = 15;
        exp_v = {1'b1, 1'b1, exp_sck(k), m_frame[15 - j], 1'b0, m_rx};
      end
      act_v = {load, busy, sck, sdo, done, rx_data};
      check("cycle{load,busy,sck,sdo,done,rx}", 32'(act_v), 32'(exp_v));

      if (k < 0) begin
        m_done = 1'b0;
        if (start) begin
          m_frame = {motor1, motor2};
          m_cap   = '0;
          k       = 0;
        end
      end else begin
        if (exp_sck(k + 1) && !exp_sck(k)) m_cap = {m_cap[14:0], sdi};
        k++;
        if (k == FRAME) begin
          k          = -1;
          m_done     = 1'b1;
          m_rx       = m_cap;
          m_idle_sdo = m_frame[0];
        end
      end
    end
  end

  // Observation of sck edges, load run lengths and done pulses.
  int          sck_edges = 0;
  logic [15:0] sdo_seq = '0;
  always @(posedge sck) begin
    sdo_seq = {sdo_seq[14:0], sdo};
    sck_edges++;
    check("sck_rise_inside_load", 32'(load), 32'd1);
  end

  int          edge_base = 0;
  int          frame_edges = 0;
  int          load_run = 0;
  int          last_load = 0;
  int          low_run = 0;
  int          last_gap = 0;
  int          done_cnt = 0;
  logic [15:0] last_seq = '0;

  always @(negedge clk) begin
    if (reset) begin
      edge_base = sck_edges;
      load_run  = 0;
    end else begin
      if (load) begin
        if (low_run > 0) last_gap = low_run;
        low_run = 0;
        load_run++;
      end else begin
        if (load_run > 0) last_load = load_run;
        load_run = 0;
        low_run++;
      end
      if (done) begin
        done_cnt++;
        frame_edges = sck_edges - edge_base;
        edge_base   = sck_edges;
        last_seq    = sdo_seq;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (done) break;
      n++;
      if (n > 2 * FRAME + 10) begin
        check({name, "_done_timeout"}, 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic wait_edges(input int n_edges, input string name);
    int target;
    int n;
    target = sck_edges + n_edges;
    n = 0;
    while (sck_edges < target && n < 2 * FRAME) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (sck_edges < target) check({name, "_sck_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic pulse_start(input logic [7:0] m1, input logic [7:0] m2);
    motor1 = m1;
    motor2 = m2;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  initial begin
    int base_done;

    // Power-on reset.
    #1 reset = 1'b1;
    #1;
    check("por_outputs", 32'({sck, sdo, load, busy, done, rx_data}), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Single AA/55 frame with loopback.
    loopback  = 1'b1;
    base_done = done_cnt;
    pulse_start(8'hAA, 8'h55);
    wait_done("aa55");
    tick();
    check("aa55_sdo_seq", 32'(last_seq), 32'h0000AA55);
    check("aa55_sck_edges", 32'(frame_edges), 32'd16);
    check("aa55_load_cycles", 32'(last_load), 32'(FRAME));
    check("aa55_rx_data", 32'(rx_data), 32'h0000AA55);
    repeat (10) tick();
    check("aa55_done_once", 32'(done_cnt - base_done), 32'd1);

    // start held high; motor changes in flight must not affect the current frame.
    base_done = done_cnt;
    motor1 = 8'hAA;
    motor2 = 8'h55;
    start  = 1'b1;
    tick();
    wait_edges(5, "held");
    motor1 = 8'h00;
    wait_edges(5, "held2");
    motor1 = 8'h12;
    motor2 = 8'h34;
    wait_done("held");
    tick();
    check("held_frame1_seq", 32'(last_seq), 32'h0000AA55);
    check("held_frame1_rx", 32'(rx_data), 32'h0000AA55);
    check("held_frame1_one_done", 32'(done_cnt - base_done), 32'd1);
    check("held_frame2_started", 32'(load), 32'd1);
    start = 1'b0;
    wait_done("b2b");
    tick();
    check("b2b_load_gap", 32'(last_gap), 32'd1);
    check("b2b_frame2_seq", 32'(last_seq), 32'h00001234);
    check("b2b_frame2_rx", 32'(rx_data), 32'h00001234);
    repeat (5) tick();

    // Abort by reset after the 7th sck rise, then a clean F0/0F frame.
    pulse_start(8'h5A, 8'hC3);
    wait_edges(7, "abort");
    base_done = done_cnt;
    #2 reset = 1'b1;
    #1;
    check("abort_outputs", 32'({sck, sdo, load, busy, done, rx_data}), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    repeat (5) tick();
    check("abort_no_done", 32'(done_cnt - base_done), 32'd0);
    pulse_start(8'hF0, 8'h0F);
    wait_done("f00f");
    tick();
    check("f00f_sdo_seq", 32'(last_seq), 32'h0000F00F);
    check("f00f_sck_edges", 32'(frame_edges), 32'd16);
    check("f00f_rx_data", 32'(rx_data), 32'h0000F00F);

    // Randomised frames: random data, random sdi, stray start pulses, random gaps.
    loopback = 1'b0;
    for (int f = 0; f < 12; f++) begin
      int gap;
      motor1 = 8'($urandom);
      motor2 = 8'($urandom);
      start  = 1'b1;
      tick();
      start  = 1'b0;
      for (int c = 0; c < FRAME + 5; c++) begin
        if (done) break;
        rnd_sdi = 1'($urandom);
        start   = ($urandom_range(0, 7) == 0);
        motor1  = 8'($urandom);
        motor2  = 8'($urandom);
        tick();
      end
      start = 1'b0;
      gap = $urandom_range(0, 4);
      repeat (gap) tick();
    end

    for (int c = 0; c < 2 * FRAME && busy; c++) tick();
    check("final_idle", 32'(busy), 32'd0);
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
